// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS-15 byte-wide pattern checker.
package prbs_pkg;

  localparam int unsigned LFSR_W     = 15;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PAT_W      = 32;
  localparam int unsigned RPT_W      = 8;
  localparam int unsigned BCNT_W     = 32;
  localparam int unsigned LOSS_CNT_W = 8;
  localparam int unsigned CONSEC_W   = 4;
  localparam int unsigned POP_W      = 4;

  // Feedback taps of x^15 + x^14 + 1
  localparam int unsigned TAP_HI = 14;
  localparam int unsigned TAP_LO = 13;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_MATCH,
    ST_SEED0,
    ST_SEED1,
    ST_CHECK
  } chk_state_e;

  typedef struct packed {
    logic [LFSR_W-1:0] next_state;
    logic [BYTE_W-1:0] byte_out;
  } prbs_step_t;

  // Eight generator steps; the earliest bit lands in bit 7.
  function automatic prbs_step_t prbs15_step8(input logic [LFSR_W-1:0] state);
    prbs_step_t        r;
    logic [LFSR_W-1:0] s;
    logic              b;
    s          = state;
    r.byte_out = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      b = s[TAP_HI] ^ s[TAP_LO];
      s = {s[LFSR_W-2:0], b};
      r.byte_out[3'(BYTE_W - 1 - i)] = b;
    end
    r.next_state = s;
    return r;
  endfunction

  // Byte idx of the preamble word; byte 0 is sent first.
  function automatic logic [BYTE_W-1:0] pattern_byte(input logic [PAT_W-1:0] pat,
                                                     input logic [1:0]       idx);
    return pat[{idx, 3'b000} +: BYTE_W];
  endfunction

  // Number of set bits in a byte.
  function automatic logic [POP_W-1:0] popcount8(input logic [BYTE_W-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prbs15_byte_predictor.sv
// PRBS-15 byte predictor: holds the LFSR and presents the next expected byte.
module prbs15_byte_predictor
  import prbs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [BYTE_W-1:0] exp_byte_o
);

  // lfsr_q is the state after exp_byte_q has been produced
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [BYTE_W-1:0] exp_byte_q, exp_byte_d;
  prbs_step_t        step;

  // Load from a seed or advance from the own prediction
  always_comb begin
    lfsr_d     = lfsr_q;
    exp_byte_d = exp_byte_q;
    step       = prbs15_step8(load_i ? seed_i : lfsr_q);
    if (clear_i) begin
      lfsr_d     = '0;
      exp_byte_d = '0;
    end else if (load_i || advance_i) begin
      lfsr_d     = step.next_state;
      exp_byte_d = step.byte_out;
    end
  end

  // LFSR and expected-byte registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= '0;
      exp_byte_q <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      exp_byte_q <= exp_byte_d;
    end
  end

  assign exp_byte_o = exp_byte_q;

endmodule

// File: rtl/prbs_pattern_checker.sv
// PRBS-15 link-test checker: preamble detect, LFSR self-sync, bit-error count.
// Optional lock-loss statistics ports: define PRBS_CHK_LOSS_STATS_EN.
module prbs_pattern_checker
  import prbs_pkg::*;
#(
  parameter int unsigned ERR_CNT_W   = 16,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BYTE_W-1:0]     data_in,
  input  logic                  data_valid,
  input  logic [PAT_W-1:0]      pattern_in,
  input  logic [RPT_W-1:0]      n_repeats,
  input  logic                  clear,
  output logic                  pattern_detected,
  output logic                  locked,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [BCNT_W-1:0]     byte_count,
  output logic                  byte_err
`ifdef PRBS_CHK_LOSS_STATS_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic                  lock_lost
`endif
);

  localparam logic [CONSEC_W-1:0] LOSS_LIM = CONSEC_W'(LOSS_THRESH);

  chk_state_e           state_q, state_d, cur_state, start_state;
  logic [1:0]           idx_q, idx_d;
  logic [RPT_W-1:0]     wcnt_q, wcnt_d;
  logic [RPT_W:0]       wcnt_inc;
  logic [BYTE_W-2:0]    seed_hi_q, seed_hi_d;
  logic [LFSR_W-1:0]    seed_c;
  logic [CONSEC_W-1:0]  consec_q, consec_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [ERR_CNT_W:0]   err_sum;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic                 locked_q, locked_d;
  logic                 byte_err_q, byte_err_d;
  logic                 det_q, det_d;
  logic [POP_W-1:0]     err_bits;
  logic [BYTE_W-1:0]    exp_byte;
  logic                 pred_load, pred_adv;
`ifdef PRBS_CHK_LOSS_STATS_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  lost_q, lost_d;
`endif

  prbs15_byte_predictor u_pred (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .load_i     (pred_load),
    .advance_i  (pred_adv),
    .seed_i     (seed_c),
    .exp_byte_o (exp_byte)
  );

  // Next-state and output logic; a zero repeat count skips the preamble phase
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    seed_hi_d  = seed_hi_q;
    consec_d   = consec_q;
    err_d      = err_q;
    bcnt_d     = bcnt_q;
    locked_d   = locked_q;
    byte_err_d = byte_err_q;
    det_d      = 1'b0;
    pred_load  = 1'b0;
    pred_adv   = 1'b0;
`ifdef PRBS_CHK_LOSS_STATS_EN
    loss_cnt_d = loss_cnt_q;
    lost_d     = lost_q;
`endif
    start_state = (n_repeats == '0) ? ST_SEED0 : ST_HUNT;
    cur_state   = (state_q == ST_HUNT && n_repeats == '0) ? ST_SEED0 : state_q;
    seed_c      = {seed_hi_q, data_in};
    wcnt_inc    = {1'b0, wcnt_q} + (RPT_W+1)'(1);
    err_bits    = popcount8(data_in ^ exp_byte);
    err_sum     = {1'b0, err_q} + (ERR_CNT_W+1)'(err_bits);

    if (clear) begin
      state_d    = start_state;
      idx_d      = '0;
      wcnt_d     = '0;
      seed_hi_d  = '0;
      consec_d   = '0;
      err_d      = '0;
      bcnt_d     = '0;
      locked_d   = 1'b0;
      byte_err_d = 1'b0;
`ifdef PRBS_CHK_LOSS_STATS_EN
      loss_cnt_d = '0;
      lost_d     = 1'b0;
`endif
    end else if (data_valid) begin
      unique case (cur_state)
        ST_HUNT: begin
          if (data_in == pattern_byte(pattern_in, 2'd0)) begin
            state_d = ST_MATCH;
            idx_d   = 2'd1;
            wcnt_d  = '0;
          end
        end
        ST_MATCH: begin
          if (data_in == pattern_byte(pattern_in, idx_q)) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (wcnt_inc >= {1'b0, n_repeats}) begin
                det_d   = 1'b1;
                state_d = ST_SEED0;
                wcnt_d  = '0;
              end else begin
                wcnt_d = wcnt_inc[RPT_W-1:0];
              end
            end
          end else begin
            wcnt_d = '0;
            if (data_in == pattern_byte(pattern_in, 2'd0)) begin
              idx_d = 2'd1;
            end else begin
              idx_d   = 2'd0;
              state_d = ST_HUNT;
            end
          end
        end
        ST_SEED0: begin
          seed_hi_d = data_in[BYTE_W-2:0];
          state_d   = ST_SEED1;
        end
        ST_SEED1: begin
          if (seed_c == '0) begin
            state_d = ST_SEED0;
          end else begin
            pred_load = 1'b1;
            state_d   = ST_CHECK;
            locked_d  = 1'b1;
            consec_d  = '0;
          end
        end
        ST_CHECK: begin
          pred_adv   = 1'b1;
          err_d      = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
          bcnt_d     = bcnt_q + BCNT_W'(1);
          byte_err_d = (err_bits != '0);
          if (err_bits == '0) begin
            consec_d = '0;
          end else if (consec_q + CONSEC_W'(1) == LOSS_LIM) begin
            consec_d = '0;
            locked_d = 1'b0;
            state_d  = ST_SEED0;
`ifdef PRBS_CHK_LOSS_STATS_EN
            lost_d = 1'b1;
            if (loss_cnt_q != '1) begin
              loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
            end
`endif
          end else begin
            consec_d = consec_q + CONSEC_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      idx_q      <= '0;
      wcnt_q     <= '0;
      seed_hi_q  <= '0;
      consec_q   <= '0;
      err_q      <= '0;
      bcnt_q     <= '0;
      locked_q   <= 1'b0;
      byte_err_q <= 1'b0;
      det_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      seed_hi_q  <= seed_hi_d;
      consec_q   <= consec_d;
      err_q      <= err_d;
      bcnt_q     <= bcnt_d;
      locked_q   <= locked_d;
      byte_err_q <= byte_err_d;
      det_q      <= det_d;
    end
  end

`ifdef PRBS_CHK_LOSS_STATS_EN
  // Lock-loss statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
      lost_q     <= 1'b0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
      lost_q     <= lost_d;
    end
  end

  assign lock_loss_count = loss_cnt_q;
  assign lock_lost       = lost_q;
`endif

  assign pattern_detected = det_q;
  assign locked           = locked_q;
  assign err_count        = err_q;
  assign byte_count       = bcnt_q;
  assign byte_err         = byte_err_q;

endmodule

// File: tb/tb_prbs_pattern_checker.sv
// Directed bench for prbs_pattern_checker (default and loss-stats builds).
module tb_prbs_pattern_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [31:0] pattern_in;
  logic [7:0]  n_repeats;
  logic        clear;
  logic        pattern_detected;
  logic        locked;
  logic [15:0] err_count;
  logic [31:0] byte_count;
  logic        byte_err;
`ifdef PRBS_CHK_LOSS_STATS_EN
  logic [7:0]  lock_loss_count;
  logic        lock_lost;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [14:0] gen_s;

  always #5 clk = ~clk;

  prbs_pattern_checker #(.ERR_CNT_W(16), .LOSS_THRESH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in          (data_in),
    .data_valid       (data_valid),
    .pattern_in       (pattern_in),
    .n_repeats        (n_repeats),
    .clear            (clear),
    .pattern_detected (pattern_detected),
    .locked           (locked),
    .err_count        (err_count),
    .byte_count       (byte_count),
    .byte_err         (byte_err)
`ifdef PRBS_CHK_LOSS_STATS_EN
    ,
    .lock_loss_count  (lock_loss_count),
    .lock_lost        (lock_lost)
`endif
  );

  // Reference bit-serial PRBS-15 source, first bit in the byte MSB
  task automatic next_prbs(output logic [7:0] b);
    logic fb;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb    = gen_s[14] ^ gen_s[13];
      gen_s = {gen_s[13:0], fb};
      b     = {b[6:0], fb};
    end
  endtask

  task automatic send(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic idle();
    data_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_valid = 1'b0; clear = 1'b0; data_in = 8'h00;
    pattern_in = 32'hDEADBEEF; n_repeats = 8'd3;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (pattern_detected !== 1'b0) begin n_bad++; $display("FAIL reset_det: got %b want 0", pattern_detected); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL reset_err: got %0h want 0", err_count); end
    n_cmp++; if (byte_count !== 32'h0) begin n_bad++; $display("FAIL reset_bcnt: got %0h want 0", byte_count); end
    n_cmp++; if (byte_err !== 1'b0) begin n_bad++; $display("FAIL reset_byte_err: got %b want 0", byte_err); end
  endtask

  task automatic test_preamble_lock();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    pattern_in = w; n_repeats = 8'd3;
    do_clear();
    for (int i = 0; i < 12; i++) begin
      send(w[(i % 4) * 8 +: 8]);
      n_cmp++; if (pattern_detected !== (i == 11)) begin n_bad++; $display("FAIL lock_det[%0d]: got %b want %b", i, pattern_detected, (i == 11)); end
    end
    idle();
    n_cmp++; if (pattern_detected !== 1'b0) begin n_bad++; $display("FAIL lock_det_after: got %b want 0", pattern_detected); end
  endtask

  task automatic test_preamble_break(input logic [7:0] miss);
    logic [7:0] q[$];
    logic [31:0] w;
    int          nwords;
    w = 32'hDEADBEEF;
    pattern_in = w; n_repeats = 8'd3;
    do_clear();
    q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF, 8'hBE};
    q.push_back(miss);
    if (miss == 8'hEF) begin
      q.push_back(8'hBE); q.push_back(8'hAD); q.push_back(8'hDE);
      nwords = 2;
    end else begin
      nwords = 3;
    end
    for (int k = 0; k < nwords * 4; k++) q.push_back(w[(k % 4) * 8 +: 8]);
    foreach (q[j]) begin
      send(q[j]);
      n_cmp++; if (pattern_detected !== (j == q.size() - 1)) begin n_bad++; $display("FAIL break_det_%0h[%0d]: got %b want %b", miss, j, pattern_detected, (j == q.size() - 1)); end
    end
  endtask

  task automatic test_prbs_clean();
    logic [7:0] b;
    logic [31:0] w;
    int          lock_bad;
    w = 32'hDEADBEEF;
    pattern_in = w; n_repeats = 8'd3;
    do_clear();
    for (int i = 0; i < 12; i++) send(w[(i % 4) * 8 +: 8]);
    n_cmp++; if (pattern_detected !== 1'b1) begin n_bad++; $display("FAIL clean_det: got %b want 1", pattern_detected); end
    gen_s = 15'h7FFF;
    lock_bad = 0;
    for (int k = 0; k < 1000; k++) begin
      next_prbs(b);
      send(b);
      n_cmp++; if (locked !== (k >= 1)) begin n_bad++; if (lock_bad < 5) $display("FAIL clean_locked[%0d]: got %b want %b", k, locked, (k >= 1)); lock_bad++; end
    end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL clean_err: got %0d want 0", err_count); end
    n_cmp++; if (byte_count !== 32'd998) begin n_bad++; $display("FAIL clean_bcnt: got %0d want 998", byte_count); end
    n_cmp++; if (byte_err !== 1'b0) begin n_bad++; $display("FAIL clean_byte_err: got %b want 0", byte_err); end
  endtask

  task automatic test_error_count();
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      next_prbs(b); send(b);
      n_cmp++; if (byte_err !== 1'b0) begin n_bad++; $display("FAIL errc_pre[%0d]: got %b want 0", i, byte_err); end
    end
    next_prbs(b); send(b ^ 8'h21);
    n_cmp++; if (byte_err !== 1'b1) begin n_bad++; $display("FAIL errc_flip1_be: got %b want 1", byte_err); end
    n_cmp++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL errc_flip1_cnt: got %0d want 2", err_count); end
    repeat (3) idle();
    n_cmp++; if (byte_err !== 1'b1) begin n_bad++; $display("FAIL errc_hold_be: got %b want 1", byte_err); end
    n_cmp++; if (byte_count !== 32'd1004) begin n_bad++; $display("FAIL errc_hold_bcnt: got %0d want 1004", byte_count); end
    for (int i = 0; i < 9; i++) begin
      next_prbs(b); send(b);
      n_cmp++; if (byte_err !== 1'b0) begin n_bad++; $display("FAIL errc_mid[%0d]: got %b want 0", i, byte_err); end
    end
    next_prbs(b); send(b ^ 8'h01);
    n_cmp++; if (byte_err !== 1'b1) begin n_bad++; $display("FAIL errc_flip2_be: got %b want 1", byte_err); end
    n_cmp++; if (err_count !== 16'd3) begin n_bad++; $display("FAIL errc_flip2_cnt: got %0d want 3", err_count); end
    next_prbs(b); send(b);
    n_cmp++; if (byte_err !== 1'b0) begin n_bad++; $display("FAIL errc_post_be: got %b want 0", byte_err); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL errc_locked: got %b want 1", locked); end
    n_cmp++; if (byte_count !== 32'd1015) begin n_bad++; $display("FAIL errc_bcnt: got %0d want 1015", byte_count); end
  endtask

  task automatic test_lock_loss();
    logic [7:0] b;
    n_repeats = 8'd0;
    do_clear();
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL loss_clr_err: got %0d want 0", err_count); end
    next_prbs(b); send(b);
    next_prbs(b); send(b);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_initial_lock: got %b want 1", locked); end
    for (int j = 0; j < 4; j++) begin
      next_prbs(b); send(b ^ 8'hFF);
      n_cmp++; if (locked !== (j < 3)) begin n_bad++; $display("FAIL loss_locked[%0d]: got %b want %b", j, locked, (j < 3)); end
    end
    n_cmp++; if (err_count !== 16'd32) begin n_bad++; $display("FAIL loss_err: got %0d want 32", err_count); end
    next_prbs(b); send(b);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_seed0: got %b want 0", locked); end
    next_prbs(b); send(b);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_relock: got %b want 1", locked); end
    next_prbs(b); send(b);
    n_cmp++; if (err_count !== 16'd32) begin n_bad++; $display("FAIL loss_err_kept: got %0d want 32", err_count); end
    n_cmp++; if (byte_count !== 32'd5) begin n_bad++; $display("FAIL loss_bcnt: got %0d want 5", byte_count); end
`ifdef PRBS_CHK_LOSS_STATS_EN
    n_cmp++; if (lock_loss_count !== 8'd1) begin n_bad++; $display("FAIL loss_stats_cnt: got %0d want 1", lock_loss_count); end
    n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL loss_stats_sticky: got %b want 1", lock_lost); end
`endif
  endtask

  task automatic test_clear_in_check();
    clear = 1'b1;
    send(8'h5A);
    clear = 1'b0;
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL clr_err: got %0d want 0", err_count); end
    n_cmp++; if (byte_count !== 32'd0) begin n_bad++; $display("FAIL clr_bcnt: got %0d want 0", byte_count); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL clr_locked: got %b want 0", locked); end
    n_cmp++; if (byte_err !== 1'b0) begin n_bad++; $display("FAIL clr_byte_err: got %b want 0", byte_err); end
`ifdef PRBS_CHK_LOSS_STATS_EN
    n_cmp++; if (lock_loss_count !== 8'd0) begin n_bad++; $display("FAIL clr_stats_cnt: got %0d want 0", lock_loss_count); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL clr_stats_sticky: got %b want 0", lock_lost); end
`endif
  endtask

  task automatic test_zero_seed();
    logic [7:0] b;
    n_repeats = 8'd0;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      send(8'h00);
      n_cmp++; if (locked !== 1'b0 || pattern_detected !== 1'b0) begin n_bad++; $display("FAIL zero_seed[%0d]: got locked=%b det=%b want 0/0", i, locked, pattern_detected); end
    end
    next_prbs(b); send(b);
    next_prbs(b); send(b);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL zero_seed_recover: got %b want 1", locked); end
  endtask

  task automatic test_saturation();
    logic [7:0] b;
    for (int r = 0; r < 2049; r++) begin
      for (int j = 0; j < 4; j++) begin next_prbs(b); send(b ^ 8'hFF); end
      if (r == 2046) begin
        n_cmp++; if (err_count !== 16'hFFE0) begin n_bad++; $display("FAIL sat_pre: got %0h want ffe0", err_count); end
      end
      if (r == 2047) begin
        n_cmp++; if (err_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hit: got %0h want ffff", err_count); end
      end
      next_prbs(b); send(b);
      next_prbs(b); send(b);
    end
    n_cmp++; if (err_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_nowrap: got %0h want ffff", err_count); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sat_relock: got %b want 1", locked); end
`ifdef PRBS_CHK_LOSS_STATS_EN
    n_cmp++; if (lock_loss_count !== 8'hFF) begin n_bad++; $display("FAIL sat_stats_cnt: got %0d want 255", lock_loss_count); end
`endif
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    next_prbs(b); send(b);
    next_prbs(b); send(b);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (err_count !== 16'h0 || byte_count !== 32'h0 || locked !== 1'b0) begin n_bad++; $display("FAIL arst_now: got err=%0h bcnt=%0h locked=%b want 0/0/0", err_count, byte_count, locked); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    n_cmp++; if (err_count !== 16'h0 || byte_err !== 1'b0) begin n_bad++; $display("FAIL arst_after: got err=%0h be=%b want 0/0", err_count, byte_err); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_preamble_lock();
    test_preamble_break(8'h00);
    test_preamble_break(8'hEF);
    test_prbs_clean();
    test_error_count();
    test_lock_loss();
    test_clear_in_check();
    test_zero_seed();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
